// File: rtl/button_pkg.sv
// Shared types and board-level defaults for the push-button conditioner.
package button_pkg;

  // Per-channel debounce / hold state machine.
  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    PRESS_WAIT   = 3'd1,
    PRESSED      = 3'd2,
    HELD         = 3'd3,
    RELEASE_WAIT = 3'd4
  } btn_state_t;

  // Board clock is 12 MHz: ~20.8 ms debounce window, 1 s long-press.
  localparam int BOARD_CLK_HZ             = 12_000_000;
  localparam int DEBOUNCE_CYCLES_DEFAULT  = 250_000;
  localparam int HOLD_CYCLES_DEFAULT      = 12_000_000;

endpackage

// File: rtl/button_channel.sv
// One button channel: 2-flop synchroniser, debounce FSM, hold counter.
// The raw pin is active-low; everything after the synchroniser is active-high.
// All outputs come straight from flops.
module button_channel
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int HOLD_CYCLES     = HOLD_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic button,
  output logic pressed,
  output logic press_pulse,
  output logic release_pulse,
  output logic hold_pulse
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam logic [DW-1:0] DB_MAX   = DW'(DEBOUNCE_CYCLES);
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES);

  logic          sync1, sync2;
  logic          s;
  btn_state_t    state, state_nx;
  logic [DW-1:0] db_cnt, db_nx, db_inc;
  logic [HW-1:0] hold_cnt, hold_nx, hold_inc;
  logic          held, held_nx;
  logic          pressed_nx, press_nx, release_nx, hold_pulse_nx;

  // Two-flop synchroniser; resets to the released (high) pin level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= button;
      sync2 <= sync1;
    end
  end

  assign s = ~sync2;

  // Saturating increments; a counter parked at its limit never wraps.
  assign db_inc   = (db_cnt == DB_MAX)     ? db_cnt   : db_cnt + 1'b1;
  assign hold_inc = (hold_cnt == HOLD_MAX) ? hold_cnt : hold_cnt + 1'b1;

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      db_cnt        <= '0;
      hold_cnt      <= '0;
      held          <= 1'b0;
      pressed       <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      hold_pulse    <= 1'b0;
    end else begin
      state         <= state_nx;
      db_cnt        <= db_nx;
      hold_cnt      <= hold_nx;
      held          <= held_nx;
      pressed       <= pressed_nx;
      press_pulse   <= press_nx;
      release_pulse <= release_nx;
      hold_pulse    <= hold_pulse_nx;
    end
  end

  // Next-state logic. The IDLE->PRESS_WAIT edge consumes the first stable
  // sample, so DEBOUNCE_CYCLES further samples are needed to accept a level.
  // `held` remembers whether the hold pulse already fired, so a release
  // bounce returns to HELD rather than PRESSED.
  always_comb begin
    state_nx      = state;
    db_nx         = db_cnt;
    hold_nx       = hold_cnt;
    held_nx       = held;
    pressed_nx    = pressed;
    press_nx      = 1'b0;
    release_nx    = 1'b0;
    hold_pulse_nx = 1'b0;
    case (state)
      IDLE: begin
        db_nx      = '0;
        hold_nx    = '0;
        held_nx    = 1'b0;
        pressed_nx = 1'b0;
        if (s) state_nx = PRESS_WAIT;
      end
      PRESS_WAIT: begin
        if (!s) begin
          state_nx = IDLE;
          db_nx    = '0;
        end else if (db_inc == DB_MAX) begin
          state_nx   = PRESSED;
          db_nx      = '0;
          hold_nx    = '0;
          held_nx    = 1'b0;
          pressed_nx = 1'b1;
          press_nx   = 1'b1;
        end else begin
          db_nx = db_inc;
        end
      end
      PRESSED: begin
        // Every cycle spent here counts toward the hold, including the one
        // that notices the pin going high.
        hold_nx = hold_inc;
        if (hold_inc == HOLD_MAX) begin
          hold_pulse_nx = 1'b1;
          held_nx       = 1'b1;
        end
        if (!s) begin
          state_nx = RELEASE_WAIT;
          db_nx    = '0;
        end else if (hold_inc == HOLD_MAX) begin
          state_nx = HELD;
        end
      end
      HELD: begin
        if (!s) begin
          state_nx = RELEASE_WAIT;
          db_nx    = '0;
        end
      end
      RELEASE_WAIT: begin
        if (s) begin
          state_nx = held ? HELD : PRESSED;
          db_nx    = '0;
        end else if (db_inc == DB_MAX) begin
          state_nx   = IDLE;
          db_nx      = '0;
          pressed_nx = 1'b0;
          release_nx = 1'b1;
        end else begin
          db_nx = db_inc;
        end
      end
      default: begin
        state_nx   = IDLE;
        db_nx      = '0;
        hold_nx    = '0;
        held_nx    = 1'b0;
        pressed_nx = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/button_conditioner.sv
// Conditions N independent active-low buttons into clean level and
// press / release / long-press pulses.
module button_conditioner
  import button_pkg::*;
#(
  parameter int N_BUTTONS       = 2,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int HOLD_CYCLES     = HOLD_CYCLES_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_BUTTONS-1:0] buttons,
  output logic [N_BUTTONS-1:0] pressed,
  output logic [N_BUTTONS-1:0] press_pulse,
  output logic [N_BUTTONS-1:0] release_pulse,
  output logic [N_BUTTONS-1:0] hold_pulse
);

  // One fully independent channel per button.
  for (genvar g = 0; g < N_BUTTONS; g++) begin : g_ch
    button_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .HOLD_CYCLES     (HOLD_CYCLES)
    ) u_ch (
      .clk           (clk),
      .rst_n         (rst_n),
      .button        (buttons[g]),
      .pressed       (pressed[g]),
      .press_pulse   (press_pulse[g]),
      .release_pulse (release_pulse[g]),
      .hold_pulse    (hold_pulse[g])
    );
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: directed scenarios with fixed expected cycle
// numbers, then random pin activity, all checked every cycle against a
// sample-history reference model.
module tb_button_conditioner;

  localparam int N = 2;
  localparam int D = 4;
  localparam int H = 10;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] buttons = '0;
  logic [N-1:0] pressed, press_pulse, release_pulse, hold_pulse;

  int n_checks = 0;
  int n_pass   = 0;

  button_conditioner #(
    .N_BUTTONS       (N),
    .DEBOUNCE_CYCLES (D),
    .HOLD_CYCLES     (H)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .buttons       (buttons),
    .pressed       (pressed),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .hold_pulse    (hold_pulse)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Rules: a level change is accepted once D+1 consecutive synchronised
  // samples disagree with the current level (the first one moves the
  // machine out of its resting state, D more complete the debounce).
  // The hold count advances on every cycle after the press whose preceding
  // sample was still "pressed", i.e. time spent waiting out a release
  // bounce does not count.
  bit   m_q1 [N];
  bit   m_q2 [N];
  bit   run_val [N];
  int   run_len [N];
  bit   prev_s [N];
  bit   level [N];
  bit   held [N];
  int   hcnt [N];
  logic [N-1:0] exp_pressed, exp_pp, exp_rp, exp_hp;

  task automatic model_reset();
    for (int ch = 0; ch < N; ch++) begin
      m_q1[ch] = 1'b1; m_q2[ch] = 1'b1;
      run_val[ch] = 1'b0; run_len[ch] = 0;
      prev_s[ch] = 1'b0; level[ch] = 1'b0; held[ch] = 1'b0; hcnt[ch] = 0;
    end
    exp_pressed = '0; exp_pp = '0; exp_rp = '0; exp_hp = '0;
  endtask

  task automatic model_step(input logic [N-1:0] b);
    bit s;
    exp_pp = '0; exp_rp = '0; exp_hp = '0;
    for (int ch = 0; ch < N; ch++) begin
      s = ~m_q2[ch];
      m_q2[ch] = m_q1[ch];
      m_q1[ch] = b[ch];
      if (s == run_val[ch]) begin
        if (run_len[ch] < 1000) run_len[ch]++;
      end else begin
        run_val[ch] = s;
        run_len[ch] = 1;
      end
      if (!level[ch]) begin
        if (s && run_len[ch] >= D + 1) begin
          exp_pp[ch] = 1'b1;
          level[ch]  = 1'b1;
          held[ch]   = 1'b0;
          hcnt[ch]   = 0;
        end
      end else begin
        if (!held[ch] && prev_s[ch]) begin
          hcnt[ch]++;
          if (hcnt[ch] == H) begin
            exp_hp[ch] = 1'b1;
            held[ch]   = 1'b1;
          end
        end
        if (!s && run_len[ch] >= D + 1) begin
          exp_rp[ch] = 1'b1;
          level[ch]  = 1'b0;
        end
      end
      prev_s[ch] = s;
      exp_pressed[ch] = level[ch];
    end
  endtask

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    else
      n_pass++;
  endtask

  task automatic compare_all();
    check("pressed", 32'(pressed), 32'(exp_pressed));
    check("press_pulse", 32'(press_pulse), 32'(exp_pp));
    check("release_pulse", 32'(release_pulse), 32'(exp_rp));
    check("hold_pulse", 32'(hold_pulse), 32'(exp_hp));
  endtask

  // ---------------- drivers ----------------
  // Drive on the falling edge, let the DUT sample on the rising edge,
  // advance the model and compare 1 ns later.
  task automatic step(input logic [N-1:0] b);
    @(negedge clk);
    buttons = b;
    @(posedge clk);
    model_step(b);
    #1;
    compare_all();
  endtask

  // One-cycle asynchronous reset pulse; outputs must drop immediately.
  // Release is placed just after a rising edge so the next step() lands on
  // the first edge after deassertion.
  task automatic pulse_reset(input logic [N-1:0] b);
    @(negedge clk);
    buttons = b;
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  task automatic settle();
    for (int i = 0; i < 12; i++) step('1);
  endtask

  // ---------------- scenarios ----------------
  int first_pp, pp_cnt, hp_at, hp_cnt, rp_at, rp_cnt, ch1_act, pr_low;
  int rem [N];
  logic [N-1:0] rb;

  initial begin
    // Reset with both buttons already held down.
    model_reset();
    rst_n = 1'b0;
    buttons = 2'b00;
    repeat (3) begin
      @(posedge clk);
      #1;
      compare_all();
    end
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    first_pp = -1; pp_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      step(2'b00);
      if (press_pulse == 2'b11) begin
        pp_cnt++;
        if (first_pp < 0) first_pp = i;
      end
    end
    check("rst_press_at", first_pp, 6);
    check("rst_press_width", pp_cnt, 1);
    check("rst_pressed_both", 32'(pressed), 32'h3);
    settle();

    // Clean press on channel 0 starting at step 10.
    first_pp = -1; pp_cnt = 0; ch1_act = 0;
    for (int i = 0; i < 24; i++) begin
      step((i >= 10) ? 2'b10 : 2'b11);
      if (press_pulse[0]) begin
        pp_cnt++;
        if (first_pp < 0) first_pp = i;
      end
      if (pressed[1] | press_pulse[1] | release_pulse[1] | hold_pulse[1]) ch1_act++;
    end
    check("clean_press_at", first_pp, 16);
    check("clean_press_cnt", pp_cnt, 1);
    check("clean_ch1_quiet", ch1_act, 0);
    settle();
    settle();

    // Bounce rejection: 3 low / 1 high, five times.
    pp_cnt = 0; pr_low = 0;
    for (int i = 0; i < 30; i++) begin
      step(((i < 20) && ((i % 4) != 3)) ? 2'b10 : 2'b11);
      if (press_pulse[0] | release_pulse[0] | hold_pulse[0]) pp_cnt++;
      if (pressed[0]) pr_low++;
    end
    check("bounce_pulses", pp_cnt, 0);
    check("bounce_pressed", pr_low, 0);

    // Long press: 30 cycles low, then released.
    first_pp = -1; hp_at = -1; hp_cnt = 0; rp_at = -1;
    for (int i = 0; i < 44; i++) begin
      step((i < 30) ? 2'b10 : 2'b11);
      if (press_pulse[0] && first_pp < 0) first_pp = i;
      if (hold_pulse[0]) begin
        hp_cnt++;
        if (hp_at < 0) hp_at = i;
      end
      if (release_pulse[0] && rp_at < 0) rp_at = i;
    end
    check("long_press_at", first_pp, 6);
    check("long_hold_at", hp_at, 16);
    check("long_hold_cnt", hp_cnt, 1);
    check("long_release_at", rp_at, 36);
    settle();

    // Release bounce: pin high for 2 cycles while PRESSED. The hold moves
    // out by the two cycles spent waiting out the bounce.
    hp_at = -1; hp_cnt = 0; rp_cnt = 0; pr_low = 0;
    for (int i = 0; i < 30; i++) begin
      step((i == 8 || i == 9) ? 2'b11 : 2'b10);
      if (hold_pulse[0]) begin
        hp_cnt++;
        if (hp_at < 0) hp_at = i;
      end
      if (release_pulse[0]) rp_cnt++;
      if (i >= 6 && !pressed[0]) pr_low++;
    end
    check("rb_no_release", rp_cnt, 0);
    check("rb_pressed_kept", pr_low, 0);
    check("rb_hold_cnt", hp_cnt, 1);
    check("rb_hold_at", hp_at, 18);
    for (int i = 0; i < 10; i++) step(2'b11);
    settle();

    // Mid-press reset: drop immediately, then re-qualify.
    for (int i = 0; i < 8; i++) step(2'b10);
    check("mid_pressed_before", 32'(pressed[0]), 32'h1);
    pulse_reset(2'b10);
    check("mid_pressed_drop", 32'(pressed[0]), 32'h0);
    first_pp = -1; pp_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      step(2'b10);
      if (press_pulse[0]) begin
        pp_cnt++;
        if (first_pp < 0) first_pp = i;
      end
    end
    check("mid_fresh_press_at", first_pp, 6);
    check("mid_fresh_press_cnt", pp_cnt, 1);
    settle();

    // Random pin activity on both channels with occasional resets.
    rb = '1;
    for (int ch = 0; ch < N; ch++) rem[ch] = $urandom_range(1, 20);
    for (int c = 0; c < 3000; c++) begin
      for (int ch = 0; ch < N; ch++) begin
        if (rem[ch] == 0) begin
          rb[ch]  = ~rb[ch];
          rem[ch] = rb[ch] ? $urandom_range(1, 12) : $urandom_range(1, 30);
        end
        rem[ch]--;
      end
      if ($urandom_range(0, 499) == 0) pulse_reset(rb);
      else step(rb);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
